// File: rtl/exp_bit_streamer.sv
// Streams the exponent held in a registered-in/registered-out ROM as a serial bit stream,
// top word first, MSB first, with leading zero bits suppressed.
module exp_bit_streamer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned NUM_WORDS  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      dataout,
    output logic                  bit_out,
    output logic                  bit_valid,
    input  logic                  bit_ready,
    output logic                  bit_last,
    output logic                  busy,
    output logic                  done,
    output logic                  zero_exp
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        LOAD,
        SHIFT,
        FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [WIDTH-1:0]      sreg_q, sreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  seen_one_q, seen_one_d;

    logic in_shift;
    logic msb;
    logic valid;
    logic consume;

    // Suppressed leading zeros drain one per cycle regardless of the consumer.
    assign in_shift = (state_q == SHIFT);
    assign msb      = sreg_q[WIDTH-1];
    assign valid    = in_shift & (seen_one_q | msb);
    assign consume  = in_shift & ((~seen_one_q & ~msb) | (valid & bit_ready));

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            seen_one_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            sreg_q     <= sreg_d;
            bit_cnt_q  <= bit_cnt_d;
            seen_one_q <= seen_one_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        sreg_d     = sreg_q;
        bit_cnt_d  = bit_cnt_q;
        seen_one_d = seen_one_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    word_idx_d = ADDR_WIDTH'(NUM_WORDS - 1);
                    seen_one_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT:  state_d = LOAD;
            LOAD: begin
                sreg_d    = dataout;
                bit_cnt_d = CNT_W'(WIDTH - 1);
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (consume) begin
                    sreg_d     = sreg_q << 1;
                    seen_one_d = seen_one_q | msb;
                    bit_cnt_d  = bit_cnt_q - CNT_W'(1);
                    if (bit_cnt_q == '0) begin
                        if (word_idx_q != '0) begin
                            word_idx_d = word_idx_q - ADDR_WIDTH'(1);
                            state_d    = FETCH;
                        end else begin
                            state_d = FINISH;
                        end
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only.
    assign addr      = word_idx_q;
    assign bit_out   = in_shift & msb;
    assign bit_valid = valid;
    assign bit_last  = valid & (word_idx_q == '0) & (bit_cnt_q == '0);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign zero_exp  = (state_q == FINISH) & ~seen_one_q;

endmodule

// File: tb/tb_exp_bit_streamer.sv
// Directed bench for exp_bit_streamer with a two-word exponent behind a registered ROM model.
module tb_exp_bit_streamer;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned ADDR_WIDTH = 7;
    localparam int unsigned NUM_WORDS  = 2;
    localparam int          BUDGET     = 600;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      dataout;
    logic                  bit_out;
    logic                  bit_valid;
    logic                  bit_ready;
    logic                  bit_last;
    logic                  busy;
    logic                  done;
    logic                  zero_exp;

    exp_bit_streamer #(
        .WIDTH     (WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .addr     (addr),
        .dataout  (dataout),
        .bit_out  (bit_out),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .bit_last (bit_last),
        .busy     (busy),
        .done     (done),
        .zero_exp (zero_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered address in, registered data out: data valid two cycles after addr.
    logic [WIDTH-1:0]      mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] addr_q;
    always @(posedge clk) begin
        addr_q  <= addr;
        dataout <= mem[addr_q];
    end

    // first/done_cyc are cycles after the start-sampling cycle; -1 = never, done_cyc 0 = unchecked.
    typedef struct packed {
        logic [31:0] w1;
        logic [31:0] w0;
        logic        rnd;
        logic        poke;
        int          first;
        int          nbits;
        int          done_cyc;
        logic        zero;
    } vec_t;

    vec_t vecs [8];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input int id, input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL v%0d %s: got %0h expected %0h", id, name, act, exp);
        end
    endtask

    task automatic chk_reset(input int id);
        chk(id, "rst_addr",      64'(addr),      64'd0);
        chk(id, "rst_bit_out",   64'(bit_out),   64'd0);
        chk(id, "rst_bit_valid", 64'(bit_valid), 64'd0);
        chk(id, "rst_bit_last",  64'(bit_last),  64'd0);
        chk(id, "rst_busy",      64'(busy),      64'd0);
        chk(id, "rst_done",      64'(done),      64'd0);
        chk(id, "rst_zero_exp",  64'(zero_exp),  64'd0);
    endtask

    task automatic run_one(input vec_t v, input int id);
        int          first, nb, done_cyc, nlast, bad_last, bad_stab, bad_zero, addr_chg;
        logic [63:0] got;
        logic        prev_stall, prev_bit, zcap;
        logic [ADDR_WIDTH-1:0] prev_addr, addr_done;
        first = -1; nb = 0; done_cyc = 0; nlast = 0; bad_last = 0;
        bad_stab = 0; bad_zero = 0; addr_chg = 0; got = '0;
        prev_stall = 1'b0; prev_bit = 1'b0; zcap = 1'b0; addr_done = '1;
        mem[1] = v.w1;
        mem[0] = v.w0;
        @(negedge clk);
        start     = 1'b1;
        bit_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk(id, "busy_at_fetch", 64'(busy), 64'd1);
        chk(id, "addr_at_fetch", 64'(addr), 64'(NUM_WORDS - 1));
        prev_addr = addr;
        for (int cyc = 1; cyc < BUDGET; cyc++) begin
            if (cyc > 1) @(negedge clk);
            bit_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = v.poke && (cyc == 2 || cyc == 20 || cyc == 40);
            if (prev_stall && (bit_out !== prev_bit || bit_valid !== 1'b1)) bad_stab++;
            if (addr !== prev_addr) addr_chg++;
            prev_addr = addr;
            if (bit_last === 1'b1) begin
                nlast++;
                if (!(bit_valid === 1'b1 && nb == v.nbits - 1)) bad_last++;
            end
            if (zero_exp === 1'b1 && done !== 1'b1) bad_zero++;
            if (bit_valid === 1'b1 && first < 0) first = cyc;
            if (bit_valid === 1'b1 && bit_ready) begin
                got = {got[62:0], bit_out};
                nb++;
            end
            prev_stall = (bit_valid === 1'b1) && !bit_ready;
            prev_bit   = bit_out;
            if (done === 1'b1) begin
                done_cyc  = cyc;
                zcap      = zero_exp;
                addr_done = addr;
                if (bit_last === 1'b1) bad_last++;
                start = v.poke;
                break;
            end
        end
        chk(id, "done_seen",   64'(done_cyc != 0), 64'd1);
        chk(id, "first_valid", 64'(first), 64'(v.first));
        chk(id, "nbits",       64'(nb), 64'(v.nbits));
        chk(id, "value",       got, {v.w1, v.w0});
        chk(id, "zero_exp",    64'(zcap), 64'(v.zero));
        chk(id, "nlast",       64'(nlast), 64'(v.nbits > 0 ? 1 : 0));
        chk(id, "bad_last",    64'(bad_last), 64'd0);
        chk(id, "bad_stall",   64'(bad_stab), 64'd0);
        chk(id, "bad_zero",    64'(bad_zero), 64'd0);
        chk(id, "addr_steps",  64'(addr_chg), 64'(NUM_WORDS - 1));
        chk(id, "addr_done",   64'(addr_done), 64'd0);
        if (v.done_cyc != 0) chk(id, "done_cycle", 64'(done_cyc), 64'(v.done_cyc));
        @(negedge clk);
        start     = 1'b0;
        bit_ready = 1'b1;
        chk(id, "busy_after_done", 64'(busy), 64'd0);
        chk(id, "done_one_cycle",  64'(done), 64'd0);
        @(negedge clk);
        chk(id, "still_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0,  4, 64, 71, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0005, 1'b0, 1'b0, 68,  3, 71, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, -1,  0, 71, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,  4, 64, 71, 1'b0};
        vecs[4] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 35, 33, 71, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 39, 32, 71, 1'b0};
        vecs[6] = '{32'h0000_00A5, 32'h1234_5678, 1'b1, 1'b0, 28, 40,  0, 1'b0};
        vecs[7] = '{32'h0000_0003, 32'hF0F0_F0F0, 1'b0, 1'b1, 34, 34, 71, 1'b0};

        for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = '0;
        rst       = 1'b1;
        start     = 1'b0;
        bit_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset(100);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_one(vecs[i], i);

        // Abort mid-stream while word 1 is shifting out.
        mem[1] = vecs[0].w1;
        mem[0] = vecs[0].w0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk(101, "valid_before_rst", 64'(bit_valid), 64'd1);
        chk(101, "addr_before_rst",  64'(addr), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset(101);
        rst = 1'b0;
        begin
            int ndone = 0;
            int nbusy = 0;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                if (done === 1'b1) ndone++;
                if (busy !== 1'b0) nbusy++;
            end
            chk(101, "no_done_after_abort", 64'(ndone), 64'd0);
            chk(101, "idle_after_abort",    64'(nbusy), 64'd0);
        end
        run_one(vecs[0], 8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
